// File: rtl/des_key_search_ctrl_pkg.sv
// des_search_pkg: shared state encoding, default sizing and in-flight slot type
// for the DES key-search sequencer. Optional feature macro: DES_SEARCH_CNT_EN.
package des_search_pkg;
  localparam int KEY_W_DEF   = 56;
  localparam int LATENCY_DEF = 4;
  // Widest key a slot can carry; narrower keys are zero-extended into it.
  localparam int SLOT_KEY_W  = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [SLOT_KEY_W-1:0] key;
  } slot_t;
endpackage

// File: rtl/des_key_search_ctrl_if.sv
// Control/engine bundle for des_key_search_ctrl. slave = sequencer side,
// master = top-level control plus engine side. With DES_SEARCH_CNT_EN the
// bundle also carries keys_tried.
interface des_key_search_ctrl_if import des_search_pkg::*; #(
  parameter int KEY_W = KEY_W_DEF
);
  logic             start;
  logic             abort;
  logic [KEY_W-1:0] start_key;
  logic [KEY_W-1:0] end_key;
  logic             eng_ready;
  logic             match;
  logic [KEY_W-1:0] cand_key;
  logic             cand_valid;
  logic             busy;
  logic             done;
  logic             found;
  logic [KEY_W-1:0] found_key;
`ifdef DES_SEARCH_CNT_EN
  logic [KEY_W:0]   keys_tried;

  modport slave  (input  start, abort, start_key, end_key, eng_ready, match,
                  output cand_key, cand_valid, busy, done, found, found_key, keys_tried);
  modport master (output start, abort, start_key, end_key, eng_ready, match,
                  input  cand_key, cand_valid, busy, done, found, found_key, keys_tried);
`else
  modport slave  (input  start, abort, start_key, end_key, eng_ready, match,
                  output cand_key, cand_valid, busy, done, found, found_key);
  modport master (output start, abort, start_key, end_key, eng_ready, match,
                  input  cand_key, cand_valid, busy, done, found, found_key);
`endif
endinterface

// File: rtl/des_key_search_ctrl_key_counter.sv
// key_counter: candidate-key register with load and wrap-around increment.
module key_counter import des_search_pkg::*; #(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             up,
  input  logic [KEY_W-1:0] din,
  output logic [KEY_W-1:0] q
);
  // load beats up; increment wraps modulo 2^KEY_W
  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= din;
    else if (up)   q <= q + 1'b1;
  end
endmodule

// File: rtl/des_key_search_ctrl.sv
// des_key_search_ctrl: walks candidate keys start_key..end_key (inclusive,
// wrapping) into a fixed-latency DES engine, one per ready cycle, and pins a
// late match on the key that produced it. Macro DES_SEARCH_CNT_EN adds the
// keys_tried count of issued candidates.
module des_key_search_ctrl import des_search_pkg::*; #(
  parameter int KEY_W   = KEY_W_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  des_key_search_ctrl_if.slave  bus
);
  state_e           state;
  logic [KEY_W-1:0] end_q, cnt, found_key_q;
  logic             found_q, accept, last, hit, flush, inflight;
  slot_t            head, tail;
  logic             slot_unused;

  assign accept         = bus.start && !bus.abort && (state == IDLE || state == DONE);
  assign bus.cand_valid = (state == SEARCH) && bus.eng_ready;
  assign bus.cand_key   = cnt;
  assign bus.busy       = (state == SEARCH) || (state == DRAIN);
  assign bus.done       = (state == DONE);
  assign bus.found      = found_q;
  assign bus.found_key  = found_key_q;

  assign last  = bus.cand_valid && (cnt == end_q);
  assign hit   = tail.valid && bus.match && (state == SEARCH || state == DRAIN);
  assign flush = bus.abort || hit;
  assign head  = {bus.cand_valid, SLOT_KEY_W'(cnt)};
  // slot bits above KEY_W only ever hold zero extension
  assign slot_unused = ^(tail.key >> KEY_W);

  key_counter #(.KEY_W(KEY_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .up   (bus.cand_valid),
    .din  (bus.start_key),
    .q    (cnt)
  );

  // The current issue is the head slot; LATENCY-1 registered slots behind it
  // carry older keys, so the tail lines up with the engine's match output.
  generate
    if (LATENCY > 1) begin : g_sr
      slot_t sr [LATENCY-1];

      // shift in every cycle; abort or a hit throws away all live keys
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          for (int i = 0; i < LATENCY-1; i++) sr[i] <= '0;
        end else begin
          sr[0] <= head;
          for (int i = 1; i < LATENCY-1; i++) sr[i] <= sr[i-1];
        end
      end

      assign tail = sr[LATENCY-2];

      // any registered slot still awaiting its engine result
      always_comb begin
        inflight = 1'b0;
        for (int i = 0; i < LATENCY-1; i++) inflight = inflight | sr[i].valid;
      end
    end else begin : g_nosr
      assign tail     = head;
      assign inflight = 1'b0;
    end
  endgenerate

  // sequencing FSM and result capture; abort outranks everything except rst
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      end_q       <= '0;
      found_q     <= 1'b0;
      found_key_q <= '0;
    end else if (bus.abort) begin
      state       <= IDLE;
      found_q     <= 1'b0;
      found_key_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          state       <= SEARCH;
          end_q       <= bus.end_key;
          found_q     <= 1'b0;
          found_key_q <= '0;
        end
        SEARCH: if (hit) begin
          state       <= DONE;
          found_q     <= 1'b1;
          found_key_q <= tail.key[KEY_W-1:0];
        end else if (last) begin
          state <= DRAIN;
        end
        DRAIN: if (hit) begin
          state       <= DONE;
          found_q     <= 1'b1;
          found_key_q <= tail.key[KEY_W-1:0];
        end else if (!inflight) begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DES_SEARCH_CNT_EN
  logic [KEY_W:0] tried_q;

  // issued candidates since the last accepted start; holds once done
  always_ff @(posedge clk) begin
    if (rst || bus.abort || accept) tried_q <= '0;
    else if (bus.cand_valid)        tried_q <= tried_q + 1'b1;
  end

  assign bus.keys_tried = tried_q;
`else
  // keys_tried counter not built
`endif
endmodule
